fifo_chain_inj_sched: RTL

Error-injection scheduler for the K-stage ECC FIFO chain. It walks the stages in index order and drives a one-hot single-bit or double-bit inject request into one stage at a time. It then waits for that stage's matching ECC flag, or for a timeout, and counts detections, timeouts and unexpected flags. It sits beside the chain under the rad-test control logic and replaces static inject wiring.

---
 rtl/fifo_chain_inj_sched.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_chain_inj_sched.sv
// fifo_chain_inj_sched: error-injection scheduler for the K-stage ECC FIFO chain.
// It walks the unmasked stages in index order, holds a one-hot inject strobe on
// one stage, and then waits for that stage's ECC flag or for a timeout. It also
// counts detections, timeouts and flags that were not expected.
// Optional feature macro: FIFO_INJ_DBIT_PASS_EN adds a double-bit pass after the
// single-bit pass. When the macro is undefined, double-bit injection is disabled.
module fifo_chain_inj_sched #(
  parameter int K      = 48,
  parameter int HOLD_W = 8,
  parameter int TMO_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [K-1:0]         stage_mask_i,
  input  logic [HOLD_W-1:0]    hold_cycles_i,
  input  logic [TMO_W-1:0]     timeout_i,
  output logic [K-1:0]         injectsbiterr_o,
  output logic [K-1:0]         injectdbiterr_o,
  input  logic [K-1:0]         sbiterr_i,
  input  logic [K-1:0]         dbiterr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [$clog2(K)-1:0] cur_stage_o,
  output logic                 cur_dbit_o,
  output logic [CNT_W-1:0]     sbit_det_cnt_o,
  output logic [CNT_W-1:0]     dbit_det_cnt_o,
  output logic [CNT_W-1:0]     tmo_cnt_o,
  output logic [CNT_W-1:0]     unexp_cnt_o
);

  localparam int SW = $clog2(K);
  localparam int PW = $clog2(K + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_SEL, ST_HOLD, ST_WAIT, ST_NEXT, ST_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_ptr;
  logic [SW-1:0]      r_cur;
  logic               r_dbit;
  logic [HOLD_W-1:0]  r_hold;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_detSeen;
  logic [K-1:0]       r_injS;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_sCnt;
  logic [CNT_W-1:0]   r_tCnt;
  logic [CNT_W-1:0]   r_uCnt;

  logic [K-1:0]       w_cand;
  logic               w_found;
  logic [SW-1:0]      w_selIdx;
  logic [K-1:0]       w_curOneHot;
  logic [K-1:0]       w_selOneHot;
  logic [K-1:0]       w_expS;
  logic [K-1:0]       w_expD;
  logic               w_expHit;
  logic               w_det;
  logic               w_tmo;
  logic               w_unexp;
  logic [HOLD_W-1:0]  w_holdLoad;

  // A result counter holds at all-ones and does not wrap.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Find the lowest unmasked stage at or above the scan pointer.
  always_comb begin
    w_cand   = ~stage_mask_i & ({K{1'b1}} << r_ptr);
    w_found  = 1'b0;
    w_selIdx = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_found  = 1'b1;
        w_selIdx = SW'(i);
      end
    end
  end

  // Compute the expected-flag masks and the per-cycle detect, timeout and unexpected events.
  always_comb begin
    w_curOneHot = {{(K-1){1'b0}}, 1'b1} << r_cur;
    w_selOneHot = {{(K-1){1'b0}}, 1'b1} << w_selIdx;
    w_expS      = (r_state != ST_IDLE && !r_dbit) ? w_curOneHot : '0;
`ifdef FIFO_INJ_DBIT_PASS_EN
    w_expD      = (r_state != ST_IDLE && r_dbit) ? w_curOneHot : '0;
`else
    w_expD      = '0;
`endif
    w_expHit    = |((sbiterr_i & w_expS) | (dbiterr_i & w_expD));
    w_det       = !abort_i && w_expHit &&
                  ((r_state == ST_HOLD && !r_detSeen) || r_state == ST_WAIT);
    w_tmo       = !abort_i && !w_expHit && r_state == ST_WAIT && r_tmo == TMO_W'(1);
    w_unexp     = !abort_i && r_state != ST_IDLE &&
                  ((|(sbiterr_i & ~w_expS)) || (|(dbiterr_i & ~w_expD)));
    w_holdLoad  = (hold_cycles_i == '0) ? HOLD_W'(1) : hold_cycles_i;
  end

  // Next-state logic; abort has the final say.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_next = ST_SEL;
      ST_SEL: begin
        if (w_found) begin
          w_next = ST_HOLD;
        end else begin
`ifdef FIFO_INJ_DBIT_PASS_EN
          w_next = r_dbit ? ST_DONE : ST_SEL;
`else
          w_next = ST_DONE;
`endif
        end
      end
      ST_HOLD: if (r_hold == HOLD_W'(1)) w_next = (r_detSeen || w_expHit) ? ST_NEXT : ST_WAIT;
      ST_WAIT: if (w_expHit || r_tmo == TMO_W'(1)) w_next = ST_NEXT;
      ST_NEXT: w_next = ST_SEL;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (abort_i) w_next = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Scan pointer, armed stage, pass type, hold and timeout counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ptr     <= '0;
      r_cur     <= '0;
      r_dbit    <= 1'b0;
      r_hold    <= '0;
      r_tmo     <= '0;
      r_detSeen <= 1'b0;
    end else if (!abort_i) begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_ptr  <= '0;
            r_dbit <= 1'b0;
          end
        end
        ST_SEL: begin
          if (w_found) begin
            r_cur     <= w_selIdx;
            r_hold    <= w_holdLoad;
            r_detSeen <= 1'b0;
          end else begin
`ifdef FIFO_INJ_DBIT_PASS_EN
            if (!r_dbit) begin
              r_dbit <= 1'b1;
              r_ptr  <= '0;
            end
`endif
          end
        end
        ST_HOLD: begin
          r_hold <= r_hold - HOLD_W'(1);
          if (w_det) r_detSeen <= 1'b1;
          if (r_hold == HOLD_W'(1)) r_tmo <= timeout_i;
        end
        ST_WAIT: if (r_tmo != '0) r_tmo <= r_tmo - TMO_W'(1);
        ST_NEXT: r_ptr <= PW'(r_cur) + PW'(1);
        default: ;
      endcase
    end
  end

  // Result counters: cleared by start, then saturating increments while a scan is running.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sCnt <= '0;
      r_tCnt <= '0;
      r_uCnt <= '0;
    end else if (r_state == ST_IDLE && start_i && !abort_i) begin
      r_sCnt <= '0;
      r_tCnt <= '0;
      r_uCnt <= '0;
    end else begin
      if (w_det && !r_dbit) r_sCnt <= satInc(r_sCnt);
      if (w_tmo)            r_tCnt <= satInc(r_tCnt);
      if (w_unexp)          r_uCnt <= satInc(r_uCnt);
    end
  end

  // Registered status and single-bit inject outputs, decoded from the state being entered.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_injS <= '0;
    end else begin
      r_busy <= (w_next != ST_IDLE);
      r_done <= (w_next == ST_DONE);
      r_injS <= (w_next == ST_HOLD && !r_dbit) ?
                ((r_state == ST_SEL) ? w_selOneHot : w_curOneHot) : '0;
    end
  end

`ifdef FIFO_INJ_DBIT_PASS_EN
  logic [K-1:0]     r_injD;
  logic [CNT_W-1:0] r_dCnt;

  // Double-bit inject strobe and detection counter for the second pass.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_injD <= '0;
      r_dCnt <= '0;
    end else begin
      r_injD <= (w_next == ST_HOLD && r_dbit) ?
                ((r_state == ST_SEL) ? w_selOneHot : w_curOneHot) : '0;
      if (r_state == ST_IDLE && start_i && !abort_i) r_dCnt <= '0;
      else if (w_det && r_dbit)                      r_dCnt <= satInc(r_dCnt);
    end
  end

  assign injectdbiterr_o = r_injD;
  assign dbit_det_cnt_o  = r_dCnt;
`else
  assign injectdbiterr_o = '0;
  assign dbit_det_cnt_o  = '0;
`endif

  assign injectsbiterr_o = r_injS;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign cur_stage_o     = r_cur;
  assign cur_dbit_o      = r_dbit;
  assign sbit_det_cnt_o  = r_sCnt;
  assign tmo_cnt_o       = r_tCnt;
  assign unexp_cnt_o     = r_uCnt;

endmodule
